// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer for EX; owns architectural HI/LO.
// Latency: DIV/DIVU stall 33 cycles, then DONE; MULT/MULTU stall 33 cycles (2 with MDU_FAST_MUL_EN).
// Backpressure: raises div_mul_stall while busy; DONE waits for pipe_hold release before committing.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   ex_valid, ex_op     - EX instruction valid and MDU opcode (0 none, 1 MULT, 2 MULTU,
//                         3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none)
//   ex_rs_val, ex_rt_val- rs / rt operands
//   pipe_hold           - EX held by another stall source
//   flush               - kills the EX instruction this cycle
//   div_mul_stall       - holds IF..EX while an operation is outstanding
//   hi, lo              - architectural HI/LO
//   busy                - FSM not idle
//
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiply; otherwise the
// multiply is a 32-step shift-add sharing the divider's iteration counter.

module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_rs_val,
    input  logic [31:0] ex_rt_val,
    input  logic        pipe_hold,
    input  logic        flush,
    output logic        div_mul_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Latched operation context; decouples the iteration from whatever EX does next.
    logic        op_div;
    logic        sign_q;
    logic        sign_r;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // ------------------------------------------------------------------
    // Decode of the EX instruction
    // ------------------------------------------------------------------
    logic        is_md_op;
    logic        is_signed_op;
    logic        is_div_op;
    logic        start_req;
    logic        mt_wr;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;

    assign is_md_op     = (ex_op == OP_MULT) || (ex_op == OP_MULTU) ||
                          (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
    assign is_signed_op = (ex_op == OP_MULT) || (ex_op == OP_DIV);
    assign is_div_op    = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
    assign start_req    = ex_valid && is_md_op && !flush;

    // MTHI/MTLO only while idle and only when the instruction really moves on.
    assign mt_wr        = (state == ST_IDLE) && ex_valid && !pipe_hold && !flush &&
                          ((ex_op == OP_MTHI) || (ex_op == OP_MTLO));

    assign a_neg        = is_signed_op && ex_rs_val[31];
    assign b_neg        = is_signed_op && ex_rt_val[31];
    assign mag_a_in     = a_neg ? (32'd0 - ex_rs_val) : ex_rs_val;
    assign mag_b_in     = b_neg ? (32'd0 - ex_rt_val) : ex_rt_val;

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    // Restoring divide step on acc = {rem, quot}: shift left, trial-subtract the
    // divisor from the 33-bit partial remainder, keep it if no borrow.
    logic [32:0] div_partial;
    logic [33:0] div_diff;
    logic        div_ok;
    logic [63:0] div_next;

    assign div_partial = acc[63:31];
    assign div_diff    = {1'b0, div_partial} - {2'b00, mag_b};
    assign div_ok      = !div_diff[33];
    assign div_next    = {(div_ok ? div_diff[31:0] : div_partial[31:0]), acc[30:0], div_ok};

    logic [63:0] step_next;
    logic        last_iter;

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod;

    assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};
    assign step_next = op_div ? div_next : fast_prod;
    assign last_iter = op_div ? (cnt == 5'd31) : 1'b1;
`else
    // Shift-add multiply on acc = {partial product, multiplier}: add the
    // multiplicand when the multiplier LSB is set, then shift right with carry.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_next  = {mul_sum, acc[31:1]};
    assign step_next = op_div ? div_next : mul_next;
    assign last_iter = (cnt == 5'd31);
`endif

    // Sign correction on the final raw magnitude result.
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [63:0] prod_fix;

    assign quot_fix = sign_q ? (32'd0 - step_next[31:0])  : step_next[31:0];
    assign rem_fix  = sign_r ? (32'd0 - step_next[63:32]) : step_next[63:32];
    assign prod_fix = sign_q ? (64'd0 - step_next)        : step_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // The instruction leaves EX either by flush (discard) or by
                // advancing once no other stall source holds it (commit).
                if (flush || !pipe_hold) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        div_mul_stall = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_IDLE: begin
                div_mul_stall = start_req;
            end
            ST_BUSY: begin
                div_mul_stall = 1'b1;
                busy          = 1'b1;
            end
            ST_DONE: begin
                busy          = 1'b1;
            end
            default: begin
                div_mul_stall = 1'b0;
                busy          = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch and iteration datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        op_div <= is_div_op;
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        mag_a  <= mag_a_in;
                        mag_b  <= mag_b_in;
                        // Divider shifts the dividend out of the low half;
                        // the multiplier shifts the multiplier out of it.
                        acc    <= is_div_op ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
                        cnt    <= 5'd0;
                    end
                end
                ST_BUSY: begin
                    if (!flush) begin
                        acc <= step_next;
                        cnt <= cnt + 5'd1;
                        if (last_iter) begin
                            if (op_div) begin
                                res_hi <= rem_fix;
                                res_lo <= quot_fix;
                            end else begin
                                res_hi <= prod_fix[63:32];
                                res_lo <= prod_fix[31:0];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Architectural HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (mt_wr) begin
            if (ex_op == OP_MTHI) begin
                hi <= ex_rs_val;
            end else begin
                lo <= ex_rs_val;
            end
        end else if ((state == ST_DONE) && !flush && !pipe_hold) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against an arithmetic reference.
// Latency: each operation is driven to completion before the next one starts.
// Backpressure: exercises pipe_hold at start and in DONE, plus flush and reset aborts.

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic        pipe_hold;
    logic        flush;
    logic        div_mul_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_STALL = 2;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    mdu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_rs_val     (ex_rs_val),
        .ex_rt_val     (ex_rt_val),
        .pipe_hold     (pipe_hold),
        .flush         (flush),
        .div_mul_stall (div_mul_stall),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        r  = 64'd0;
        case (op)
            3'd1: begin
                sp = sa * sb;
                r  = sp;
            end
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) begin
                    // all-ones magnitude quotient, |a| remainder, then signs applied
                    r = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else begin
                    r[31:0]  = 32'(sa / sb);
                    r[63:32] = 32'(sa % sb);
                end
            end
            3'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
            default: r = {m_hi, m_lo};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Run one MDU op to completion, holding DONE for 'hold' cycles.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input bit hold_start);
        logic [63:0] exp;
        int          stall_cnt;
        int          exp_stall;
        exp       = ref_result(op, a, b);
        exp_stall = (op == 3'd1 || op == 3'd2) ? MUL_STALL : DIV_STALL;
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_rs_val = a;
        ex_rt_val = b;
        pipe_hold = hold_start;
        stall_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!div_mul_stall) break;
            stall_cnt++;
            @(posedge clk); #1;
            // EX contents are irrelevant once the operation has been latched
            ex_rs_val = $urandom;
            ex_rt_val = $urandom;
            ex_op     = 3'($urandom_range(5, 6));
            pipe_hold = 1'($urandom_range(0, 1));
        end
        check({tag, "_stall_len"}, 64'(stall_cnt), 64'(exp_stall));
        check({tag, "_done_busy"}, 64'(busy), 64'd1);
        pipe_hold = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_hold_busy"}, 64'(busy), 64'd1);
            check({tag, "_hold_stall"}, 64'(div_mul_stall), 64'd0);
            check({tag, "_hold_hilo"}, {hi, lo}, {m_hi, m_lo});
        end
        pipe_hold = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        m_hi     = exp[63:32];
        m_lo     = exp[31:0];
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_rs_val = v;
        pipe_hold = 1'b0;
        @(negedge clk);
        check("mt_stall", 64'(div_mul_stall), 64'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        if (op == 3'd5) m_hi = v;
        else            m_lo = v;
        @(negedge clk);
        check("mt_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sc;

        rst       = 1'b1;
        ex_valid  = 1'b0;
        ex_op     = 3'd0;
        ex_rs_val = 32'd0;
        ex_rt_val = 32'd0;
        pipe_hold = 1'b0;
        flush     = 1'b0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(div_mul_stall), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases
        do_op("divu_100_7", 3'd4, 32'd100, 32'd7, 0, 1'b0);
        check("divu_100_7_lit", {hi, lo}, {32'd2, 32'd14});
        do_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check("div_m7_2_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        check("div_ovf_lit", {hi, lo}, {32'd0, 32'h8000_0000});
        do_op("divu_by0", 3'd4, 32'd5, 32'd0, 0, 1'b0);
        check("divu_by0_lit", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        do_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        check("mult_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 0, 1'b1);
        check("multu_lit", {hi, lo}, {32'd1, 32'hFFFF_FFFE});

        // HI/LO preset; MTHI under pipe_hold must not write
        do_mt(3'd5, 32'hA5A5_A5A5);
        do_mt(3'd6, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_op     = 3'd5;
        ex_rs_val = 32'h1234_5678;
        pipe_hold = 1'b1;
        @(posedge clk); #1;
        ex_valid  = 1'b0;
        ex_op     = 3'd0;
        pipe_hold = 1'b0;
        @(negedge clk);
        check("mt_held_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);

        // Flush on BUSY cycle 10
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_op     = 3'd3;
        ex_rs_val = 32'd1000;
        ex_rt_val = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_pre", 64'(div_mul_stall), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        @(negedge clk);
        check("flush_busy_stall", 64'(div_mul_stall), 64'd0);
        check("flush_busy_busy", 64'(busy), 64'd0);
        check("flush_busy_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

        // Flush in DONE
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_op     = 3'd3;
        ex_rs_val = 32'hFFFF_FF9C;
        ex_rt_val = 32'd7;
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!div_mul_stall) break;
            sc++;
        end
        check("flush_done_stall_len", 64'(sc), 64'(DIV_STALL));
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        @(negedge clk);
        check("flush_done_busy", 64'(busy), 64'd0);
        check("flush_done_stall", 64'(div_mul_stall), 64'd0);
        check("flush_done_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

        // DONE held by pipe_hold for 5 cycles
        do_op("divu_9_3_hold", 3'd4, 32'd9, 32'd3, 5, 1'b0);
        check("divu_9_3_lit", {hi, lo}, {32'd0, 32'd3});

        // Random operations mixed with MTHI/MTLO
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_mt(3'($urandom_range(5, 6)), $urandom);
            end
            rop = 3'($urandom_range(1, 4));
            ra  = pick_operand();
            rb  = pick_operand();
            do_op("rand", rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of BUSY
        @(posedge clk); #1;
        ex_valid  = 1'b1;
        ex_op     = 3'd4;
        ex_rs_val = 32'd77;
        ex_rt_val = 32'd5;
        repeat (5) @(posedge clk);
        #2;
        rst      = 1'b1;
        ex_valid = 1'b0;
        ex_op    = 3'd0;
        #1;
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_stall", 64'(div_mul_stall), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        do_op("after_rst", 3'd3, 32'd50, 32'hFFFF_FFF9, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
